m68k_irq_ctrl: RTL and testbench
================================

// Module: m68k_irq_ctrl
// PURPOSE
//   Parametrised 68000 interrupt controller for the Taito F2 family tops: N sources (VBL start/end, DMA,
//   save-state NMI, per-board extras) each with its own IPL level, edge/level mode and polarity.
//   Drives fx68k IPL0n-2n, generates VPAn autovector for IACK cycles, clears the acknowledged source.
//   Adds mask, SW clear, same-level multi-source arbitration and input sync.
// PARAMETERS
//   N_SRC        4                          number of interrupt sources (1..16)
//   SRC_LEVEL    {3'd7,3'd6,3'd5,3'd5}      packed [N_SRC][3] IPL per source, index 0 = LSB; 0 = source disabled
//   SRC_EDGE     4'b1111                    per source: 1 = edge-latched, 0 = level (follows input)
//   SRC_POL      4'b1111                    per source: 1 = rising edge / active-high, 0 = falling / active-low
//   SYNC_STAGES  0                          input synchroniser flops per source (0..3)
// PORTS
//   clk            in   1       system clock
//   reset_n        in   1       asynchronous active-low reset
//   src_in         in   N_SRC   raw interrupt request lines
//   src_mask       in   N_SRC   1 = source enabled toward CPU
//   sw_clear       in   N_SRC   1-cycle pulse, clears edge-pending bit
//   cpu_fc         in   3       68000 function code
//   cpu_addr       in   3       CPU A3..A1 (acknowledged level during IACK)
//   cpu_as_n       in   1       address strobe
//   cpu_lds_n      in   1       lower data strobe
//   ipl_n          out  3       to fx68k IPL2n..IPL0n (active-low level)
//   vpa_n          out  1       autovector request, low during IACK
//   iack_n         out  1       low while IACK cycle in progress (other glue qualifies DTACK on it)
//   pending        out  N_SRC   per-source pending status (debug/CPU readback)
//   active_level   out  3       level currently presented (= ~ipl_n)
// BEHAVIOUR
//   Reset (async, reset_n=0): pending=0, ipl_n=3'b111, active_level=0, sync/prev flops=0, primed=0.
//   - vpa_n/iack_n go high combinationally since as_n is high in reset.
//   primed: set on first clk after reset release; that cycle only loads prev, no edge detection,
//   so a line already active at release does not fire.
//   Input path: src_in -> SYNC_STAGES flops -> s[i]; prev[i] <= s[i] every cycle.
//   Edge source i: event = primed & (SRC_POL[i] ? s&~prev : ~s&prev).
//   pending[i] set on event; cleared by sw_clear[i] or IACK selection; set wins over any clear same cycle.
//   Level source i: pending[i] <= (s[i]==SRC_POL[i]) registered, 1 cycle; sw_clear and IACK have no effect.
//   Masked sources still latch pending; mask only gates IPL and IACK selection.
//   eligible[i] = pending[i] & src_mask[i] & (SRC_LEVEL[i]!=0).
//   ipl_n <= ~max(SRC_LEVEL[i] over eligible), registered.
//   - latency src_in edge -> ipl_n = SYNC_STAGES + 2 clk.
//   IACK: iack = (cpu_fc==3'b111) & ~cpu_as_n & ~cpu_lds_n, combinational.
//   - iack_n = vpa_n = ~iack; combinational, no added latency.
//   iack_rise = iack & ~iack_d (iack_d registered, reset 0); exactly one clear per IACK cycle.
//   On iack_rise: clear lowest-index eligible EDGE source with SRC_LEVEL==cpu_addr.
//   - other same-level sources stay pending and re-assert the level on the next cycle.
//   - no match (spurious / level source / masked): no state change, vpa_n still asserted.
//   Level 7 is non-maskable at the CPU; controller treats it like any level, edge mode only retriggers.
//   ipl_n is never forced by iack; it tracks eligible set (drops 1 clk after the clear).
// STRUCTURE
//   Package f2_irq_pkg:
//   - typedef logic [2:0] ipl_t
//   - localparam FC_IACK = 3'b111, IPL_NONE = 3'b111
//   - function max_level(eligible, levels)
//   Sub-module irq_src_det (one per source via generate): sync chain, prev, edge/level decode, pending flop.
//   Top holds primed, iack_d, clear selection (priority encoder lowest index), IPL register.
// TESTING
//   1 Defaults; pulse src_in[0] 0->1 at t -> ipl_n=3'b010 (lvl5) at t+2; IACK addr=5 -> vpa_n=0, pending[0]=0, ipl_n=111 next clk.
//   2 src 0,1 both lvl5 fire same cycle -> ipl_n=010; IACK5 clears only [0]; ipl_n stays 010; 2nd IACK clears [1] -> 111.
//   3 src[3] lvl7 + src[2] lvl6 pending -> ipl_n=000; IACK7 -> ipl_n=001; IACK6 -> 111.
//   4 src_mask[2]=0, event on src[2] -> ipl_n=111, pending[2]=1; set mask=1 -> ipl_n=001 after 1 clk.
//   5 Edge event same cycle as sw_clear / IACK clear -> pending stays 1; SRC_EDGE[1]=0 active-low src held 0 -> IACK leaves pending 1.
//   6 src_in high during reset, release -> no pending; reset_n low mid-IACK -> ipl_n=111, pending=0 immediately.

Source files
------------

// File: rtl/f2_irq_pkg.sv
// Shared types and helpers for the Taito F2 68000 interrupt controller.
package f2_irq_pkg;

    typedef logic [2:0] ipl_t;

    localparam logic [2:0] FC_IACK  = 3'b111;
    localparam ipl_t       IPL_NONE = 3'b111;

    // Highest IPL among flagged sources; levels packed 3 bits per source, index 0 = LSB.
    function automatic ipl_t max_level(input logic [15:0] eligible, input logic [47:0] levels);
        ipl_t best;
        best = '0;
        for (int i = 0; i < 16; i++) begin
            if (eligible[i] && (levels[3*i +: 3] > best)) begin
                best = levels[3*i +: 3];
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/m68k_irq_ctrl_if.sv
// 68000 interrupt-side bus: function code, IACK address/strobes, IPL and autovector lines.
interface m68k_irq_ctrl_if;
    import f2_irq_pkg::*;

    logic [2:0] cpu_fc;
    logic [2:0] cpu_addr;
    logic       cpu_as_n;
    logic       cpu_lds_n;
    ipl_t       ipl_n;
    logic       vpa_n;
    logic       iack_n;

    modport master (
        output cpu_fc, cpu_addr, cpu_as_n, cpu_lds_n,
        input  ipl_n, vpa_n, iack_n
    );

    modport slave (
        input  cpu_fc, cpu_addr, cpu_as_n, cpu_lds_n,
        output ipl_n, vpa_n, iack_n
    );

endinterface

// File: rtl/irq_src_det.sv
// One interrupt source: optional input synchroniser, edge/level decode and pending flop.
module irq_src_det #(
    parameter int unsigned SYNC_STAGES = 0,
    parameter logic        SRC_EDGE    = 1'b1,
    parameter logic        SRC_POL     = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic primed,
    input  logic src_in,
    input  logic sw_clear,
    input  logic iack_clr,
    output logic pending
);

    logic s;
    logic prev_q, prev_d;
    logic pending_q, pending_d;
    logic evt;

    if (SYNC_STAGES == 0) begin : g_direct
        assign s = src_in;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q, sync_d;

        always_comb begin
            sync_d = SYNC_STAGES'({sync_q, src_in});
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync_q <= '0;
            end else begin
                sync_q <= sync_d;
            end
        end

        assign s = sync_q[SYNC_STAGES-1];
    end

    always_comb begin
        prev_d = s;
        evt    = primed & (SRC_POL ? (s & ~prev_q) : (~s & prev_q));
        // A new event beats any clear landing in the same cycle.
        if (SRC_EDGE) begin
            pending_d = evt | (pending_q & ~(sw_clear | iack_clr));
        end else begin
            pending_d = (s == SRC_POL);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/m68k_irq_ctrl.sv
// Parametrised 68000 interrupt controller: per-source detect, masking, IPL encode, autovector IACK.
module m68k_irq_ctrl
    import f2_irq_pkg::*;
#(
    parameter int unsigned          N_SRC       = 4,
    parameter logic [3*N_SRC-1:0]   SRC_LEVEL   = {3'd7, 3'd6, 3'd5, 3'd5},
    parameter logic [N_SRC-1:0]     SRC_EDGE    = '1,
    parameter logic [N_SRC-1:0]     SRC_POL     = '1,
    parameter int unsigned          SYNC_STAGES = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_SRC-1:0] src_in,
    input  logic [N_SRC-1:0] src_mask,
    input  logic [N_SRC-1:0] sw_clear,
    m68k_irq_ctrl_if.slave   bus,
    output logic [N_SRC-1:0] pending,
    output ipl_t             active_level
);

    logic             primed_q, primed_d;
    logic             iack_d_q, iack_d_d;
    ipl_t             ipl_n_q, ipl_n_d;
    logic             iack, iack_rise;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] clr_sel;

    assign iack = (bus.cpu_fc == FC_IACK) & ~bus.cpu_as_n & ~bus.cpu_lds_n;

    always_comb begin
        primed_d  = 1'b1;
        iack_d_d  = iack;
        iack_rise = iack & ~iack_d_q;
        eligible  = '0;
        clr_sel   = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            eligible[i] = pending[i] & src_mask[i] & (SRC_LEVEL[3*i +: 3] != 3'd0);
        end
        // Walk downward so the lowest matching index is the one left selected.
        if (iack_rise) begin
            for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
                if (eligible[i] && SRC_EDGE[i] && (SRC_LEVEL[3*i +: 3] == bus.cpu_addr)) begin
                    clr_sel    = '0;
                    clr_sel[i] = 1'b1;
                end
            end
        end
        ipl_n_d = ~max_level(16'(eligible), 48'(SRC_LEVEL));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            primed_q <= 1'b0;
            iack_d_q <= 1'b0;
            ipl_n_q  <= IPL_NONE;
        end else begin
            primed_q <= primed_d;
            iack_d_q <= iack_d_d;
            ipl_n_q  <= ipl_n_d;
        end
    end

    for (genvar i = 0; i < int'(N_SRC); i++) begin : g_src
        irq_src_det #(
            .SYNC_STAGES(SYNC_STAGES),
            .SRC_EDGE   (SRC_EDGE[i]),
            .SRC_POL    (SRC_POL[i])
        ) u_det (
            .clk     (clk),
            .reset_n (reset_n),
            .primed  (primed_q),
            .src_in  (src_in[i]),
            .sw_clear(sw_clear[i]),
            .iack_clr(clr_sel[i]),
            .pending (pending[i])
        );
    end

    assign bus.ipl_n    = ipl_n_q;
    assign bus.vpa_n    = ~iack;
    assign bus.iack_n   = ~iack;
    assign active_level = ~ipl_n_q;

endmodule

// File: tb/tb_m68k_irq_ctrl.sv
// Directed + random bench for m68k_irq_ctrl: default instance and a level/sync variant.
module tb_m68k_irq_ctrl;
    import f2_irq_pkg::*;

    localparam logic [3:0] EDGE0 = 4'b1111, POL0 = 4'b1111;
    localparam logic [3:0] EDGE1 = 4'b1101, POL1 = 4'b1101;
    localparam int         SS0 = 0, SS1 = 1;

    logic       clk;
    logic       reset_n;
    logic [3:0] src_in, src_mask, sw_clear;
    logic [2:0] fc, addr;
    logic       as_n, lds_n;
    logic [3:0] pend0, pend1;
    ipl_t       act0, act1;

    int n_chk, n_pass;

    m68k_irq_ctrl_if bus0 ();
    m68k_irq_ctrl_if bus1 ();

    assign bus0.cpu_fc = fc;   assign bus0.cpu_addr = addr;
    assign bus0.cpu_as_n = as_n; assign bus0.cpu_lds_n = lds_n;
    assign bus1.cpu_fc = fc;   assign bus1.cpu_addr = addr;
    assign bus1.cpu_as_n = as_n; assign bus1.cpu_lds_n = lds_n;

    m68k_irq_ctrl #(
        .N_SRC(4), .SRC_LEVEL({3'd7, 3'd6, 3'd5, 3'd5}), .SRC_EDGE(EDGE0), .SRC_POL(POL0),
        .SYNC_STAGES(SS0)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .src_in(src_in), .src_mask(src_mask),
        .sw_clear(sw_clear), .bus(bus0), .pending(pend0), .active_level(act0)
    );

    m68k_irq_ctrl #(
        .N_SRC(4), .SRC_LEVEL({3'd7, 3'd6, 3'd5, 3'd5}), .SRC_EDGE(EDGE1), .SRC_POL(POL1),
        .SYNC_STAGES(SS1)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .src_in(src_in), .src_mask(src_mask),
        .sw_clear(sw_clear), .bus(bus1), .pending(pend1), .active_level(act1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, one slot per instance.
    logic [3:0] m_pend [2];
    logic [2:0] m_lvl [2];
    logic [3:0] m_prev [2];
    logic       m_primed [2];
    logic       m_iack_prev [2];
    logic [3:0] m_hist [$];

    function automatic int lvl_of(input int i);
        case (i)
            0, 1:    return 5;
            2:       return 6;
            default: return 7;
        endcase
    endfunction

    function automatic logic [3:0] s_of(input int d);
        int ss;
        ss = (d == 0) ? SS0 : SS1;
        if (ss == 0) return src_in;
        if (m_hist.size() >= ss) return m_hist[ss-1];
        return 4'h0;
    endfunction

    function automatic logic cur_iack();
        return (fc == 3'b111) && !as_n && !lds_n;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pend[d] = '0; m_lvl[d] = '0; m_prev[d] = '0;
            m_primed[d] = 1'b0; m_iack_prev[d] = 1'b0;
        end
        m_hist.delete();
    endtask

    task automatic model_step();
        if (!reset_n) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            logic [3:0] s, edg, pol, nxt;
            int victim, best, lv;
            logic elig, fired;
            s = s_of(d);
            edg = (d == 0) ? EDGE0 : EDGE1;
            pol = (d == 0) ? POL0 : POL1;
            victim = -1;
            best = 0;
            for (int i = 0; i < 4; i++) begin
                lv = lvl_of(i);
                elig = m_pend[d][i] && src_mask[i] && (lv != 0);
                if (elig && lv > best) best = lv;
                if (cur_iack() && !m_iack_prev[d] && elig && edg[i] && lv == int'(addr)
                    && victim < 0) victim = i;
            end
            for (int i = 0; i < 4; i++) begin
                if (edg[i]) begin
                    fired = m_primed[d] && (pol[i] ? (s[i] && !m_prev[d][i])
                                                   : (!s[i] && m_prev[d][i]));
                    if (fired) nxt[i] = 1'b1;
                    else if (sw_clear[i] || victim == i) nxt[i] = 1'b0;
                    else nxt[i] = m_pend[d][i];
                end else begin
                    nxt[i] = (s[i] == pol[i]);
                end
            end
            m_prev[d] = s;
            m_primed[d] = 1'b1;
            m_iack_prev[d] = cur_iack();
            m_lvl[d] = 3'(best);
            m_pend[d] = nxt;
        end
        m_hist.push_front(src_in);
        if (m_hist.size() > 3) m_hist.pop_back();
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            ipl_t e_ipl;
            logic e_v;
            e_ipl = ~m_lvl[d];
            e_v = !cur_iack();
            chk($sformatf("ipl_n[%0d]", d), 16'(d != 0 ? bus1.ipl_n : bus0.ipl_n), 16'(e_ipl));
            chk($sformatf("active_level[%0d]", d), 16'(d != 0 ? act1 : act0), 16'(m_lvl[d]));
            chk($sformatf("pending[%0d]", d), 16'(d != 0 ? pend1 : pend0), 16'(m_pend[d]));
            chk($sformatf("vpa_n[%0d]", d), 16'(d != 0 ? bus1.vpa_n : bus0.vpa_n), 16'(e_v));
            chk($sformatf("iack_n[%0d]", d), 16'(d != 0 ? bus1.iack_n : bus0.iack_n), 16'(e_v));
        end
    endtask

    task automatic cyc(input int n = 1);
        for (int k = 0; k < n; k++) begin
            model_step();
            @(posedge clk);
            #1;
            check_all();
        end
    endtask

    task automatic iack_on(input logic [2:0] a);
        fc = 3'b111; addr = a; as_n = 1'b0; lds_n = 1'b0;
    endtask

    task automatic iack_off();
        fc = 3'b000; as_n = 1'b1; lds_n = 1'b1;
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        reset_n = 1'b0; src_in = '0; src_mask = 4'hF; sw_clear = '0;
        fc = '0; addr = '0; as_n = 1'b1; lds_n = 1'b1;
        model_reset();
        cyc(2);
        chk("rst_ipl_n", 16'(bus0.ipl_n), 16'h7);
        chk("rst_pending", 16'(pend0), 16'h0);
        chk("rst_vpa_n", 16'(bus0.vpa_n), 16'h1);
        chk("rst_active", 16'(act0), 16'h0);
        reset_n = 1'b1;
        cyc(1);

        // Single lvl5 source through IACK.
        src_in = 4'b0001;
        cyc(1);
        chk("t1_pend_set", 16'(pend0[0]), 16'h1);
        chk("t1_ipl_lat", 16'(bus0.ipl_n), 16'h7);
        cyc(1);
        chk("t1_ipl5", 16'(bus0.ipl_n), 16'b010);
        src_in = 4'b0000;
        iack_on(3'd5);
        #1;
        chk("t1_vpa_low", 16'(bus0.vpa_n), 16'h0);
        chk("t1_iack_low", 16'(bus0.iack_n), 16'h0);
        cyc(1);
        chk("t1_pend_clr", 16'(pend0[0]), 16'h0);
        cyc(1);
        chk("t1_ipl_none", 16'(bus0.ipl_n), 16'h7);
        iack_off();
        cyc(1);

        // Two lvl5 sources, one cleared per IACK.
        src_in = 4'b0011;
        cyc(2);
        chk("t2_ipl5", 16'(bus0.ipl_n), 16'b010);
        src_in = 4'b0000;
        iack_on(3'd5);
        cyc(1);
        chk("t2_first_clr", 16'(pend0), 16'b0010);
        cyc(1);
        chk("t2_ipl_hold", 16'(bus0.ipl_n), 16'b010);
        iack_off();
        cyc(1);
        iack_on(3'd5);
        cyc(1);
        chk("t2_second_clr", 16'(pend0), 16'h0);
        cyc(1);
        chk("t2_ipl_none", 16'(bus0.ipl_n), 16'h7);
        iack_off();
        cyc(1);

        // Level 7 over level 6.
        src_in = 4'b1100;
        cyc(2);
        chk("t3_ipl7", 16'(bus0.ipl_n), 16'b000);
        src_in = 4'b0000;
        iack_on(3'd7);
        cyc(2);
        chk("t3_ipl6", 16'(bus0.ipl_n), 16'b001);
        iack_off();
        cyc(1);
        iack_on(3'd6);
        cyc(2);
        chk("t3_ipl_none", 16'(bus0.ipl_n), 16'h7);
        iack_off();
        cyc(1);

        // Masked source still latches.
        src_mask = 4'b1011;
        src_in = 4'b0100;
        cyc(2);
        chk("t4_ipl_masked", 16'(bus0.ipl_n), 16'h7);
        chk("t4_pend_masked", 16'(pend0[2]), 16'h1);
        src_mask = 4'hF;
        cyc(1);
        chk("t4_ipl_unmask", 16'(bus0.ipl_n), 16'b001);
        src_in = 4'b0000;
        sw_clear = 4'b0100;
        cyc(1);
        sw_clear = '0;
        chk("t4_swclr", 16'(pend0), 16'h0);
        cyc(1);

        // Set beats clear; level source ignores clears.
        src_in = 4'b0001;
        sw_clear = 4'b0001;
        cyc(1);
        sw_clear = '0;
        chk("t5_set_vs_sw", 16'(pend0[0]), 16'h1);
        src_in = 4'b0000;
        cyc(1);
        src_in = 4'b0001;
        iack_on(3'd5);
        cyc(1);
        chk("t5_set_vs_iack", 16'(pend0[0]), 16'h1);
        iack_off();
        src_in = 4'b0000;
        sw_clear = 4'b0001;
        cyc(1);
        sw_clear = '0;
        chk("t5_sw_done", 16'(pend0), 16'h0);
        iack_on(3'd5);
        sw_clear = 4'b0010;
        cyc(1);
        sw_clear = '0;
        iack_off();
        cyc(1);
        chk("t5_level_hold", 16'(pend1[1]), 16'h1);
        src_in = 4'b0010;
        cyc(2);
        chk("t5_level_follow", 16'(pend1[1]), 16'h0);
        src_in = 4'b0000;
        cyc(2);

        // Active at release does not fire; async reset mid-IACK.
        src_in = 4'hF;
        cyc(1);
        reset_n = 1'b0;
        model_reset();
        cyc(2);
        reset_n = 1'b1;
        cyc(2);
        chk("t6_no_fire", 16'(pend0), 16'h0);
        chk("t6_ipl_none", 16'(bus0.ipl_n), 16'h7);
        src_in = 4'h0;
        cyc(1);
        src_in = 4'b0001;
        cyc(2);
        chk("t6_ipl5", 16'(bus0.ipl_n), 16'b010);
        iack_on(3'd5);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("t6_async_ipl", 16'(bus0.ipl_n), 16'h7);
        chk("t6_async_pend", 16'(pend0), 16'h0);
        check_all();
        cyc(1);
        iack_off();
        reset_n = 1'b1;
        src_in = '0;
        cyc(2);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            src_in = src_in ^ (4'($urandom) & 4'($urandom));
            src_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            sw_clear = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 3) == 0) begin
                if (as_n) iack_on(3'($urandom_range(4, 7)));
                else iack_off();
            end
            cyc(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
